// File: rtl/mul_pkg.sv
// Shared widths, state encoding and step decode for the sequential 32x32 multiply unit.
package mul_pkg;

  localparam int HALF_W = 16;
  localparam int OP_W   = 32;
  localparam int RES_W  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Partial-product weight for each half-product step: lo*lo, lo*hi, hi*lo, hi*hi.
  function automatic logic [5:0] step_shift(input logic [1:0] step);
    case (step)
      2'd0:    return 6'd0;
      2'd3:    return 6'd32;
      default: return 6'd16;
    endcase
  endfunction

endpackage

// File: rtl/mul32_seq_ctrl_if.sv
// Operand issue / result writeback handshake bundle for mul32_seq_ctrl.
interface mul32_seq_ctrl_if;
  import mul_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  result;
  logic              busy;

  modport master (
    output flush, in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/Multiplier.sv
// 16x16 unsigned combinational multiplier; the single arithmetic core shared by all four steps.
module Multiplier
  import mul_pkg::*;
(
  input  logic [HALF_W-1:0] md,
  input  logic [HALF_W-1:0] mr,
  output logic [OP_W-1:0]   product
);

  assign product = {{HALF_W{1'b0}}, md} * {{HALF_W{1'b0}}, mr};

endmodule

// File: rtl/mul32_seq_ctrl.sv
// Sequential 32x32 unsigned multiply: four 16x16 half-products through one Multiplier,
// shifted and accumulated into a 64-bit result, with valid/ready on both sides.
module mul32_seq_ctrl
  import mul_pkg::*;
#(
  parameter bit PP_REG = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  mul32_seq_ctrl_if.slave  bus
);

  state_t             state_q, state_d;
  logic [1:0]         step_q, step_d;
  logic [OP_W-1:0]    a_q, a_d;
  logic [OP_W-1:0]    b_q, b_d;
  logic [RES_W-1:0]   acc_q, acc_d;
  logic [OP_W-1:0]    pp_q, pp_d;

  logic [HALF_W-1:0]  md, mr;
  logic [OP_W-1:0]    product;
  logic [OP_W-1:0]    pp_src;
  logic [1:0]         acc_step;
  logic [RES_W-1:0]   addend;

  // step[1] selects the a half, step[0] the b half.
  assign md = step_q[1] ? a_q[OP_W-1:HALF_W] : a_q[HALF_W-1:0];
  assign mr = step_q[0] ? b_q[OP_W-1:HALF_W] : b_q[HALF_W-1:0];

  Multiplier u_mult (
    .md      (md),
    .mr      (mr),
    .product (product)
  );

  // With the product register the add trails the issued step by one; in DRAIN step_q
  // has wrapped to 0, so step_q-1 lands on the final hi*hi weight.
  assign pp_src   = PP_REG ? pp_q : product;
  assign acc_step = PP_REG ? step_q - 2'd1 : step_q;
  assign addend   = {{(RES_W-OP_W){1'b0}}, pp_src} << step_shift(acc_step);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    pp_d    = product;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          step_d  = 2'd0;
          state_d = MUL;
        end
      end
      MUL: begin
        step_d = step_q + 2'd1;
        if (!PP_REG || step_q != 2'd0) begin
          acc_d = acc_q + addend;
        end
        if (step_q == 2'd3) begin
          state_d = PP_REG ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        acc_d   = acc_q + addend;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      state_d = IDLE;
      step_d  = 2'd0;
      acc_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      pp_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      pp_q    <= pp_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = acc_q;

endmodule
